// File: rtl/expr_eval_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : expr_eval_arbiter
// Description : Round-robin arbiter that shares one combinational expression
//               evaluator among NREQ requesters. It registers the granted
//               operands, waits LAT cycles, captures the result and returns it
//               tagged with the requester id on a valid/ready response port.
//               Only one operation is in flight at a time.
// Revision    : 1.0 - initial release
// ============================================================================
module expr_eval_arbiter #(
    parameter int NREQ = 4,
    parameter int OPW  = 30,
    parameter int RESW = 90,
    parameter int LAT  = 2,
    parameter int CNTW = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*OPW-1:0]      req_a,
    input  logic [NREQ*OPW-1:0]      req_b,
    output logic [NREQ-1:0]          req_ready,
    output logic [OPW-1:0]           eval_a,
    output logic [OPW-1:0]           eval_b,
    input  logic [RESW-1:0]          eval_y,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [RESW-1:0]          rsp_data,
    output logic [$clog2(NREQ)-1:0]  rsp_id,
    output logic                     busy,
    output logic [CNTW-1:0]          ops_done
);

    localparam int IDW = $clog2(NREQ);
    localparam int CW  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [IDW-1:0]   rr_ptr;
    logic [CW-1:0]    cnt;
    logic [IDW-1:0]   grant_idx;
    logic             grant_found;
    logic [IDW-1:0]   cand;
    logic             accept;
    logic             capture;
    logic             handshake;

    // Round-robin search starting at rr_ptr; first valid requester wins.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = IDW'((int'(rr_ptr) + k) % NREQ);
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and the single-cycle event strobes that drive the datapath.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        capture    = 1'b0;
        handshake  = 1'b0;
        case (state)
            IDLE: begin
                if (grant_found) begin
                    accept     = 1'b1;
                    state_next = EVAL;
                end
            end
            EVAL: begin
                if (cnt == '0) begin
                    capture    = 1'b1;
                    state_next = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    handshake  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Grant is only presented while the FSM can actually take the request.
    assign req_ready = (accept && !reset) ? (NREQ'(1) << grant_idx) : '0;
    assign busy      = (state != IDLE);

    // Operand capture, settle counter, result capture and completion count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr    <= '0;
            cnt       <= '0;
            eval_a    <= '0;
            eval_b    <= '0;
            rsp_data  <= '0;
            rsp_id    <= '0;
            rsp_valid <= 1'b0;
            ops_done  <= '0;
        end else begin
            if (accept) begin
                eval_a <= req_a[grant_idx*OPW +: OPW];
                eval_b <= req_b[grant_idx*OPW +: OPW];
                rsp_id <= grant_idx;
                rr_ptr <= (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + IDW'(1);
                cnt    <= CW'(LAT - 1);
            end else if (state == EVAL && cnt != '0) begin
                cnt <= cnt - CW'(1);
            end
            if (capture) begin
                rsp_data  <= eval_y;
                rsp_valid <= 1'b1;
            end else if (handshake) begin
                rsp_valid <= 1'b0;
                ops_done  <= ops_done + CNTW'(1);
            end
        end
    end

endmodule
`default_nettype wire
